// File: rtl/mem_bus_if.sv
// MEM-stage bus interface: routes each access either to the zero-wait scratchpad
// or to the shared system bus (request/grant, then strobe/ready), stalling the pipe meanwhile.
module mem_bus_if #(
    parameter int               SEL_W   = 3,
    parameter logic [SEL_W-1:0] SPM_SEL = 3'b011
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic [29:0] addr,
    input  logic        as_,
    input  logic        rw,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] spm_rd_data,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        ACCESS = 2'b10,
        STALL  = 2'b11
    } state_t;

    state_t      state_q,       state_d;
    logic        bus_req_q,     bus_req_d;
    logic        bus_as_q,      bus_as_d;
    logic [29:0] bus_addr_q,    bus_addr_d;
    logic        bus_rw_q,      bus_rw_d;
    logic [31:0] bus_wr_data_q, bus_wr_data_d;
    logic [31:0] rd_buf_q,      rd_buf_d;

    logic hit_s;
    logic launch_s;

    assign hit_s = (addr[29:30-SEL_W] == SPM_SEL);
    // No access is started while reset is held, so nothing leaks out during reset.
    assign launch_s = (state_q == IDLE) && !flush && !as_ && reset_;

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = !(launch_s && hit_s);

    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rw      = bus_rw_q;
    assign bus_wr_data = bus_wr_data_q;

    // State and bus master registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_addr_q    <= 30'h0;
            bus_rw_q      <= 1'b1;
            bus_wr_data_q <= 32'h0;
            rd_buf_q      <= 32'h0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_addr_q    <= bus_addr_d;
            bus_rw_q      <= bus_rw_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_buf_q      <= rd_buf_d;
        end
    end

    // Next-state, bus register updates and the combinational busy/rd_data outputs.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_addr_d    = bus_addr_q;
        bus_rw_d      = bus_rw_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_buf_d      = rd_buf_q;
        busy          = 1'b0;
        rd_data       = 32'h0;

        case (state_q)
            IDLE: begin
                if (launch_s) begin
                    if (hit_s) begin
                        rd_data = spm_rd_data;
                    end else begin
                        busy          = 1'b1;
                        bus_req_d     = 1'b0;
                        bus_addr_d    = addr;
                        bus_rw_d      = rw;
                        bus_wr_data_d = wr_data;
                        state_d       = REQ;
                    end
                end else begin
                    busy    = 1'b0;
                    rd_data = 32'h0;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (!bus_grnt_) begin
                    bus_as_d = 1'b0;
                    state_d  = ACCESS;
                end else begin
                    bus_req_d = 1'b0;
                    state_d   = REQ;
                end
            end
            ACCESS: begin
                // The strobe is only ever asserted for the first ACCESS cycle.
                bus_as_d = 1'b1;
                busy     = bus_rdy_;
                if (!bus_rdy_) begin
                    rd_data       = bus_rd_data;
                    bus_req_d     = 1'b1;
                    rd_buf_d      = bus_rd_data;
                    bus_addr_d    = 30'h0;
                    bus_rw_d      = 1'b1;
                    bus_wr_data_d = 32'h0;
                    if (stall) begin
                        state_d = STALL;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            STALL: begin
                rd_data = rd_buf_q;
                if (!stall) begin
                    state_d = IDLE;
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b1;
                bus_as_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: a per-cycle vector table plus hand-written
// sequences for delayed grant/ready and stall-at-completion.
module tb_mem_bus_if;

    logic        clk;
    logic        reset_;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    int checks;
    int failures;

    // addr[29:27] == 3'b011 selects the scratchpad
    localparam logic [29:0] A_SPM = 30'h1800_0004;
    localparam logic [29:0] A_BUS = 30'h0000_0010;
    localparam logic [29:0] A_W   = 30'h0000_0020;

    mem_bus_if dut (
        .clk         (clk),
        .reset_      (reset_),
        .stall       (stall),
        .flush       (flush),
        .busy        (busy),
        .addr        (addr),
        .as_         (as_),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .spm_rd_data (spm_rd_data),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, fl, as, rw;
        logic [29:0] addr;
        logic [31:0] wd, srd;
        logic        gr, rdy;
        logic [31:0] brd;
        logic        e_busy;
        logic [31:0] e_rd;
        logic        e_spm_as, e_req, e_as, e_rw;
        logic [29:0] e_addr;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic fl, input logic as, input logic rwi,
        input logic [29:0] ad, input logic [31:0] wd, input logic [31:0] srd,
        input logic gr, input logic rdy, input logic [31:0] brd,
        input logic e_busy, input logic [31:0] e_rd, input logic e_spm_as,
        input logic e_req, input logic e_as, input logic e_rw,
        input logic [29:0] e_addr, input logic [31:0] e_wd);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.as = as; v.rw = rwi;
        v.addr = ad; v.wd = wd; v.srd = srd; v.gr = gr; v.rdy = rdy; v.brd = brd;
        v.e_busy = e_busy; v.e_rd = e_rd; v.e_spm_as = e_spm_as; v.e_req = e_req;
        v.e_as = e_as; v.e_rw = e_rw; v.e_addr = e_addr; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int nas;
        checks   = 0;
        failures = 0;

        //          rst stl fl as rw addr   wd            srd           gr rdy brd            busy rd            spm req as rw addr   wd
        vecs[0]  = mk(0, 0, 0, 0, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         0, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[1]  = mk(1, 0, 0, 1, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         0, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[2]  = mk(1, 0, 0, 0, 1, A_SPM, 32'h0,        32'hCAFE_0001,1, 1, 32'h0,         0, 32'hCAFE_0001, 0, 1, 1, 1, 30'h0, 32'h0);
        vecs[3]  = mk(1, 0, 0, 0, 0, A_SPM, 32'h5555_AAAA,32'h0000_0077,1, 1, 32'h0,         0, 32'h0000_0077, 0, 1, 1, 1, 30'h0, 32'h0);
        vecs[4]  = mk(1, 0, 1, 0, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         0, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[5]  = mk(1, 0, 1, 0, 1, A_SPM, 32'h0,        32'h0000_1111,1, 1, 32'h0,         0, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[6]  = mk(1, 0, 0, 0, 0, A_W,   32'hDEAD_BEEF,32'h0,        1, 1, 32'h0,         1, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[7]  = mk(1, 0, 0, 1, 0, A_W,   32'hDEAD_BEEF,32'h0,        0, 1, 32'h0,         1, 32'h0,         1, 0, 1, 0, A_W,   32'hDEAD_BEEF);
        vecs[8]  = mk(1, 0, 0, 1, 0, A_W,   32'hDEAD_BEEF,32'h0,        1, 0, 32'h0000_0042, 0, 32'h0000_0042, 1, 0, 0, 0, A_W,   32'hDEAD_BEEF);
        vecs[9]  = mk(1, 0, 0, 1, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         0, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[10] = mk(1, 0, 0, 0, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         1, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[11] = mk(1, 0, 0, 1, 1, A_BUS, 32'h0,        32'h0,        0, 1, 32'h0,         1, 32'h0,         1, 0, 1, 1, A_BUS, 32'h0);
        vecs[12] = mk(1, 0, 1, 1, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         1, 32'h0,         1, 0, 0, 1, A_BUS, 32'h0);
        vecs[13] = mk(1, 0, 1, 1, 1, A_BUS, 32'h0,        32'h0,        1, 0, 32'hABCD_0123, 0, 32'hABCD_0123, 1, 0, 1, 1, A_BUS, 32'h0);
        vecs[14] = mk(1, 0, 0, 0, 1, A_SPM, 32'h0,        32'h2222_3333,1, 1, 32'h0,         0, 32'h2222_3333, 0, 1, 1, 1, 30'h0, 32'h0);
        vecs[15] = mk(1, 0, 0, 0, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         1, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);
        vecs[16] = mk(1, 0, 0, 1, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         1, 32'h0,         1, 0, 1, 1, A_BUS, 32'h0);
        vecs[17] = mk(0, 0, 0, 1, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         1, 32'h0,         1, 0, 1, 1, A_BUS, 32'h0);
        vecs[18] = mk(1, 0, 0, 1, 1, A_BUS, 32'h0,        32'h0,        1, 1, 32'h0,         0, 32'h0,         1, 1, 1, 1, 30'h0, 32'h0);

        reset_ = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b0; rw = 1'b1;
        addr = A_BUS; wr_data = 32'h0; spm_rd_data = 32'h0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            reset_ = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fl;
            as_ = vecs[i].as; rw = vecs[i].rw; addr = vecs[i].addr;
            wr_data = vecs[i].wd; spm_rd_data = vecs[i].srd;
            bus_grnt_ = vecs[i].gr; bus_rdy_ = vecs[i].rdy; bus_rd_data = vecs[i].brd;
            @(negedge clk);
            chk($sformatf("v%0d_busy", i),        {31'h0, busy},        {31'h0, vecs[i].e_busy});
            chk($sformatf("v%0d_rd_data", i),     rd_data,              vecs[i].e_rd);
            chk($sformatf("v%0d_spm_as_", i),     {31'h0, spm_as_},     {31'h0, vecs[i].e_spm_as});
            chk($sformatf("v%0d_spm_addr", i),    {2'h0, spm_addr},     {2'h0, vecs[i].addr});
            chk($sformatf("v%0d_spm_wr", i),      spm_wr_data ^ {31'h0, spm_rw}, vecs[i].wd ^ {31'h0, vecs[i].rw});
            chk($sformatf("v%0d_bus_req_", i),    {31'h0, bus_req_},    {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_bus_as_", i),     {31'h0, bus_as_},     {31'h0, vecs[i].e_as});
            chk($sformatf("v%0d_bus_rw", i),      {31'h0, bus_rw},      {31'h0, vecs[i].e_rw});
            chk($sformatf("v%0d_bus_addr", i),    {2'h0, bus_addr},     {2'h0, vecs[i].e_addr});
            chk($sformatf("v%0d_bus_wr_data", i), bus_wr_data,          vecs[i].e_wd);
        end

        // Bus read: grant in the 3rd REQ cycle, ready in the 3rd ACCESS cycle.
        nb = 0; nas = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            reset_ = 1'b1; stall = 1'b0; flush = 1'b0; rw = 1'b1; addr = A_BUS;
            as_         = (k == 0) ? 1'b0 : 1'b1;
            bus_grnt_   = (k == 3) ? 1'b0 : 1'b1;
            bus_rdy_    = (k == 6) ? 1'b0 : 1'b1;
            bus_rd_data = (k == 6) ? 32'h1234_5678 : 32'h0;
            @(negedge clk);
            if (busy) nb = nb + 1;
            if (!bus_as_) nas = nas + 1;
            if (k == 6) chk("dly_rd_data", rd_data, 32'h1234_5678);
            if (k == 7) chk("dly_req_release", {31'h0, bus_req_}, 32'h1);
        end
        chk("dly_busy_cycles", nb, 32'd6);
        chk("dly_as_cycles", nas, 32'd1);

        // Stall asserted in the ready cycle and held three more cycles.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            reset_ = 1'b1; flush = 1'b0; rw = 1'b1;
            as_         = (k == 0 || k == 4) ? 1'b0 : 1'b1;
            addr        = (k == 4) ? A_SPM : A_BUS;
            spm_rd_data = 32'h0000_9999;
            stall       = (k >= 2 && k <= 5) ? 1'b1 : 1'b0;
            bus_grnt_   = (k == 1) ? 1'b0 : 1'b1;
            bus_rdy_    = (k == 2) ? 1'b0 : 1'b1;
            bus_rd_data = (k == 2) ? 32'h5A5A_0F0F : 32'h0;
            @(negedge clk);
            if (k >= 2 && k <= 6) begin
                chk($sformatf("stl%0d_rd_data", k), rd_data, 32'h5A5A_0F0F);
                chk($sformatf("stl%0d_busy", k), {31'h0, busy}, 32'h0);
            end
            if (k == 4) chk("stl_no_launch", {31'h0, spm_as_}, 32'h1);
            if (k == 7) begin
                chk("stl_idle_rd_data", rd_data, 32'h0);
                chk("stl_idle_busy", {31'h0, busy}, 32'h0);
                chk("stl_idle_req", {31'h0, bus_req_}, 32'h1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
